// File: rtl/uart_tx_fifo_if.sv
// Host-side write port and status outputs of the UART transmit FIFO.
// The FIFO block is the slave; the LPC decoder (or a bench) is the master.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16
);
    logic [DATA_BITS-1:0]   data;
    logic                   data_valid;
    logic                   full;
    logic [$clog2(DEPTH):0] level;
    logic                   overrun;
    logic                   busy;
    logic                   UART_TX;

    modport master (
        output data, data_valid,
        input  full, level, overrun, busy, UART_TX
    );

    modport slave (
        input  data, data_valid,
        output full, level, overrun, busy, UART_TX
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a DEPTH-entry FIFO; queued characters are sent back-to-back
// with configurable word length, parity and stop bits.
module uart_tx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int CLK_DIV   = 286,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic          LPC_CLK,
    input  logic          LPC_RST,
    uart_tx_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [LVL_W-1:0]     level_q;
    logic [LVL_W-1:0]     level_d;
    logic                 overrun_q;
    state_e               state_q;
    state_e               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     idx_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic                 tx_q;
    logic                 tx_d;

    logic full;
    logic wr_en;
    logic pop;
    logic bit_end;
    logic parity_bit;

    // A write against a full FIFO is dropped even if a pop frees a slot on the same edge.
    assign full       = (level_q == LVL_W'(DEPTH));
    assign wr_en      = bus.data_valid && !full;
    assign bit_end    = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign level_d    = level_q + LVL_W'(wr_en) - LVL_W'(pop);
    assign parity_bit = (PARITY == 1) ? ~(^shift_q) : (^shift_q);

    // NOTE: FIFO storage is not reset; level and pointers alone decide which entries are valid.
    always_ff @(posedge LPC_CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.data;
        end
    end

    // NOTE: registers use non-blocking assignments so every one of them samples pre-edge values.
    always_ff @(posedge LPC_CLK or negedge LPC_RST) begin
        if (!LPC_RST) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q   <= level_d;
            overrun_q <= bus.data_valid && full;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // idx counts stop bits here; the last one chains straight into the next frame.
                if (bit_end) begin
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        idx_d = '0;
                        if (level_q != '0) begin
                            pop     = 1'b1;
                            shift_d = mem_q[rd_ptr_q];
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The line level is registered, so it is derived from the state being entered.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[idx_d];
            ST_PARITY: tx_d = parity_bit;
            default:   tx_d = 1'b1;
        endcase
    end

    assign bus.full    = full;
    assign bus.level   = level_q;
    assign bus.overrun = overrun_q;
    assign bus.busy    = (state_q != ST_IDLE) || (level_q != '0);
    assign bus.UART_TX = tx_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Three differently configured transmitters driven with random and directed writes and
// compared every cycle against a queue-based model of the serial line.
module tb_uart_tx_fifo;
    localparam int NCFG = 3;
    // Index 0 is the rightmost byte: 8N1 d4; 7E1 d8; 7O2 d4 with a 3-cycle bit.
    localparam logic [NCFG-1:0][7:0] CFG_DB    = {8'd7, 8'd7, 8'd8};
    localparam logic [NCFG-1:0][7:0] CFG_PAR   = {8'd1, 8'd2, 8'd0};
    localparam logic [NCFG-1:0][7:0] CFG_STOP  = {8'd2, 8'd1, 8'd1};
    localparam logic [NCFG-1:0][7:0] CFG_DIV   = {8'd3, 8'd4, 8'd4};
    localparam logic [NCFG-1:0][7:0] CFG_DEPTH = {8'd4, 8'd8, 8'd4};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NCFG-1:0][7:0] drv_data;
    logic [NCFG-1:0]      drv_valid;

    logic [NCFG-1:0]      obs_tx, obs_full, obs_ovr, obs_busy;
    logic [NCFG-1:0][7:0] obs_level;
    logic [NCFG-1:0]      exp_tx, exp_full, exp_ovr, exp_busy;
    logic [NCFG-1:0][7:0] exp_level;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int DB   = int'(CFG_DB[g]);
        localparam int PAR  = int'(CFG_PAR[g]);
        localparam int STOP = int'(CFG_STOP[g]);
        localparam int DIV  = int'(CFG_DIV[g]);
        localparam int DP   = int'(CFG_DEPTH[g]);
        localparam logic [7:0] MASK = 8'((1 << DB) - 1);

        uart_tx_fifo_if #(.DATA_BITS(DB), .DEPTH(DP)) bus ();

        uart_tx_fifo #(
            .DATA_BITS(DB),
            .DEPTH    (DP),
            .CLK_DIV  (DIV),
            .PARITY   (PAR),
            .STOP_BITS(STOP)
        ) dut (
            .LPC_CLK(clk),
            .LPC_RST(rst_n),
            .bus    (bus)
        );

        assign bus.data       = drv_data[g][DB-1:0];
        assign bus.data_valid = drv_valid[g];
        assign obs_tx[g]      = bus.UART_TX;
        assign obs_full[g]    = bus.full;
        assign obs_ovr[g]     = bus.overrun;
        assign obs_busy[g]    = bus.busy;
        assign obs_level[g]   = 8'(bus.level);

        // Model: the FIFO is a queue, the line is a queue of per-cycle levels for the frame.
        logic [7:0] fifo_m [$];
        bit         wave_m [$];
        bit         m_tx     = 1'b1;
        bit         m_active = 1'b0;
        bit         m_ovr    = 1'b0;
        int         m_level  = 0;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                fifo_m.delete();
                wave_m.delete();
                m_tx     = 1'b1;
                m_active = 1'b0;
                m_ovr    = 1'b0;
                m_level  = 0;
            end else begin
                logic [7:0] ch;
                bit         full_pre;
                bit         par;
                full_pre = (fifo_m.size() == DP);
                if (wave_m.size() != 0) begin
                    m_tx     = wave_m.pop_front();
                    m_active = 1'b1;
                end else if (fifo_m.size() != 0) begin
                    ch  = fifo_m.pop_front();
                    par = ^ch;
                    if (PAR == 1) par = ~par;
                    for (int k = 0; k < DIV; k++) wave_m.push_back(1'b0);
                    for (int b = 0; b < DB; b++)
                        for (int k = 0; k < DIV; k++) wave_m.push_back(ch[b]);
                    if (PAR != 0)
                        for (int k = 0; k < DIV; k++) wave_m.push_back(par);
                    for (int k = 0; k < STOP * DIV; k++) wave_m.push_back(1'b1);
                    m_tx     = wave_m.pop_front();
                    m_active = 1'b1;
                end else begin
                    m_tx     = 1'b1;
                    m_active = 1'b0;
                end
                m_ovr = drv_valid[g] && full_pre;
                if (drv_valid[g] && !full_pre) fifo_m.push_back(drv_data[g] & MASK);
                m_level = fifo_m.size();
            end
        end

        assign exp_tx[g]    = m_tx;
        assign exp_ovr[g]   = m_ovr;
        assign exp_level[g] = 8'(m_level);
        assign exp_full[g]  = (m_level == DP);
        assign exp_busy[g]  = m_active || (m_level != 0);
    end

    task automatic compare_all();
        for (int g = 0; g < NCFG; g++) begin
            check($sformatf("tx[%0d]", g),    obs_tx[g],    exp_tx[g]);
            check($sformatf("level[%0d]", g), obs_level[g], exp_level[g]);
            check($sformatf("full[%0d]", g),  obs_full[g],  exp_full[g]);
            check($sformatf("ovr[%0d]", g),   obs_ovr[g],   exp_ovr[g]);
            check($sformatf("busy[%0d]", g),  obs_busy[g],  exp_busy[g]);
        end
    endtask

    task automatic step(input logic [NCFG-1:0] v, input logic [NCFG-1:0][7:0] d);
        drv_valid = v;
        drv_data  = d;
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        for (int g = 0; g < NCFG; g++) begin
            check($sformatf("%s_tx[%0d]", tag, g),    obs_tx[g],    1);
            check($sformatf("%s_level[%0d]", tag, g), obs_level[g], 0);
            check($sformatf("%s_full[%0d]", tag, g),  obs_full[g],  0);
            check($sformatf("%s_busy[%0d]", tag, g),  obs_busy[g],  0);
            check($sformatf("%s_ovr[%0d]", tag, g),   obs_ovr[g],   0);
        end
    endtask

    initial begin
        logic [NCFG-1:0]      v;
        logic [NCFG-1:0][7:0] d;
        drv_valid = '0;
        drv_data  = '0;

        // Reset held while writes are attempted.
        repeat (6) begin
            step(NCFG'($urandom), {8'($urandom), 8'($urandom), 8'($urandom)});
            check_reset_values("rst_hold");
        end
        drv_valid = '0;
        rst_n     = 1'b1;

        // Single frames: A5 on 8N1, 03 with even and odd 7-bit parity.
        step('1, {8'h03, 8'h03, 8'hA5});
        check("lat_level", obs_level[0], 1);
        step('0, '0);
        check("lat_tx", obs_tx[0], 0);
        check("lat_pop", obs_level[0], 0);
        repeat (39) step('0, '0);
        check("busy_end_0", obs_busy[0], 1);
        check("busy_end_1", obs_busy[1], 1);
        step('0, '0);
        check("busy_fall_0", obs_busy[0], 0);
        check("busy_fall_1", obs_busy[1], 0);
        repeat (10) step('0, '0);

        // Six consecutive writes: the sixth overflows the 4-deep FIFOs.
        for (int n = 1; n <= 6; n++) begin
            step('1, {8'($urandom), 8'($urandom), 8'($urandom)});
            if (n == 5) begin
                check("full_5th_0", obs_full[0], 1);
                check("full_5th_2", obs_full[2], 1);
            end
        end
        check("ovr_pulse_0", obs_ovr[0], 1);
        check("ovr_pulse_2", obs_ovr[2], 1);
        check("ovr_level_0", obs_level[0], 4);
        step('0, '0);
        check("ovr_clear_0", obs_ovr[0], 0);
        check("ovr_clear_2", obs_ovr[2], 0);
        repeat (260) step('0, '0);

        // Reset during data bit 3 of the first frame with two characters still queued.
        repeat (3) step('1, {8'($urandom), 8'($urandom), 8'($urandom)});
        repeat (16) step('0, '0);
        check("pre_rst_level", obs_level[0], 2);
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst_mid");
        repeat (3) step('0, '0);
        rst_n = 1'b1;
        step(3'b001, {8'h00, 8'h00, 8'h5A});
        repeat (50) step('0, '0);

        // Random traffic at low, medium and high write rates.
        for (int blk = 0; blk < 12; blk++) begin
            int rate;
            rate = (blk % 3 == 0) ? 5 : ((blk % 3 == 1) ? 35 : 90);
            repeat (200) begin
                for (int g = 0; g < NCFG; g++) begin
                    v[g] = ($urandom_range(0, 99) < rate);
                    d[g] = 8'($urandom);
                end
                step(v, d);
            end
        end

        repeat (400) step('0, '0);
        for (int g = 0; g < NCFG; g++) begin
            check($sformatf("drain_busy[%0d]", g),  obs_busy[g],  0);
            check($sformatf("drain_level[%0d]", g), obs_level[g], 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO, the next-generation replacement for the single-byte, busy-gated UART TX path behind the LPC device decoder. Bytes written by the LPC side are queued in a DEPTH-entry FIFO and serialised back-to-back with configurable word length, parity and stop bits. The `full` flag replaces the old `busy` back-pressure, so the host can burst up to DEPTH characters without polling per byte.

## Interface

Parameters:
- DATA_BITS, 8: character width, legal range 5..8; sent LSB first.
- DEPTH, 16: FIFO entries, power of two, at least 2.
- CLK_DIV, 286: LPC_CLK cycles per bit (33 MHz / 115200); at least 2.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports (one clock; reset is asynchronous and active-low):
- LPC_CLK  in  1  sole clock; all state updates on its rising edge.
- LPC_RST  in  1  asynchronous, active-low reset.
- data  in  DATA_BITS  character to enqueue.
- data_valid  in  1  write strobe; one character per cycle while high.
- full  out  1  FIFO holds DEPTH entries.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- overrun  out  1  one-cycle pulse when a write is dropped.
- busy  out  1  high while the FIFO is non-empty or a frame is on the line.
- UART_TX  out  1  serial output, idle high, registered.

## Operation

- **Write path**
  - A write occurs when `data_valid` is high at a clock edge.
  - It is accepted if and only if `full` is low at that edge (registered value).
  - A write while `full` is high is discarded and `overrun` pulses high for exactly one cycle.
  - A write while `full` is high is dropped even if a pop occurs on the same edge.
- **Pointers and level**
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `level` is tracked explicitly: +1 on an accepted write, −1 on a pop, unchanged when both happen on the same edge.
  - `full` = (level == DEPTH).
- **Transmit FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: if level > 0, pop the head into the shift register, clear the baud counter, go to START. Otherwise stay in IDLE.
  - START: drive 0 for CLK_DIV cycles, then go to DATA with the bit index at 0.
  - DATA: drive shift[idx] for CLK_DIV cycles per bit. After bit DATA_BITS−1, go to PARITY if PARITY≠0, else to STOP.
  - PARITY: drive the parity bit for CLK_DIV cycles, then go to STOP.
    - Even parity: bit = XOR of the data bits.
    - Odd parity: bit = inverted XOR of the data bits.
  - STOP: drive 1 for STOP_BITS×CLK_DIV cycles. On the last cycle:
    - if level > 0, pop and go directly to START (no idle gap);
    - else go to IDLE.
- **Baud counter:** counts 0..CLK_DIV−1 and wraps. A bit period ends when the counter equals CLK_DIV−1.
- **busy** = (state ≠ IDLE) or (level ≠ 0).

## Timing

- **Reset values:** UART_TX=1, full=0, level=0, overrun=0, busy=0, FSM in IDLE, pointers 0.
  - All outputs take these values immediately on LPC_RST low, including mid-frame. FIFO contents are discarded.
- **Latency:** a write at edge 0 into an empty, idle block gives:
  - level=1 after edge 0;
  - pop at edge 1, so level=0 and UART_TX=0 after edge 1.
- **Frame length:** (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLK_DIV cycles. Consecutive queued characters follow with zero gap.
- **overrun:** asserted in the cycle following the dropped write's edge, cleared one cycle later.
- **busy:** falls on the edge that ends the last stop bit when the FIFO is empty.

## Test plan

- **Reset:** hold LPC_RST low while toggling data_valid → UART_TX=1, level=0, full=0, busy=0, overrun=0 throughout.
- **Single frame:** CLK_DIV=4, 8N1, write 0xA5 → UART_TX low for cycles 1–4, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high for 4 cycles; busy low after cycle 40.
- **Parity and word length:** CLK_DIV=4, DATA_BITS=7.
  - Even parity, write 0x03 → parity bit 0.
  - Odd parity, write 0x03 → parity bit 1.
  - Frame length is 40 cycles with STOP_BITS=1.
- **Overflow:** DEPTH=4, CLK_DIV=4, 8N1, write 6 consecutive cycles →
  - full high after the 5th write (one entry already popped);
  - 6th write dropped, with overrun pulsing one cycle;
  - 5 frames sent back-to-back, 200 cycles with no idle high between stop and start.
- **Reset mid-frame:** assert LPC_RST during data bit 3 with 2 entries queued →
  - UART_TX=1 and level=0 immediately;
  - after release, write 0x5A → clean frame of 0x5A only.
- **Two stop bits:** STOP_BITS=2, two queued bytes → stop high for 2×CLK_DIV cycles, next start bit immediately after.
